reg_writeback_queue: RTL and testbench

//  Write side of the register file. Holds retiring results from the MEM stage
//  in program order and drains them as one register file write per cycle.

---
 rtl/reg_writeback_queue_pkg.sv | 14 +
 rtl/rwq_match.sv | 40 ++++
 rtl/reg_writeback_queue.sv | 158 +++++++++++++++
 tb/tb_reg_writeback_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared constants for the register writeback queue: default widths, depth and
// the pointer-width helper used by the top and the bypass matcher.
package reg_writeback_queue_pkg;

   localparam int RWQ_XLEN  = 32;
   localparam int RWQ_AW    = 5;
   localparam int RWQ_DEPTH = 4;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int rwqPtrWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rwq_match.sv
// Bypass search: walks the valid entries from oldest to youngest starting at
// the head slot and reports the youngest entry whose rd matches the query.
module rwq_match
   import reg_writeback_queue_pkg::*;
#(
   parameter int XLEN  = RWQ_XLEN,
   parameter int AW    = RWQ_AW,
   parameter int DEPTH = RWQ_DEPTH,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic [IW-1:0]              i_headIdx,
   input  logic [DEPTH-1:0]           i_valid,
   input  logic [DEPTH-1:0]           i_dvalid,
   input  logic [DEPTH-1:0][AW-1:0]   i_rd,
   input  logic [DEPTH-1:0][XLEN-1:0] i_data,
   input  logic [AW-1:0]              i_addr,
   output logic                       o_hit,
   output logic                       o_ready,
   output logic [XLEN-1:0]            o_data
);

   logic [IW-1:0] w_idx;

   // Later (younger) matches overwrite earlier ones; register 0 never bypasses.
   always_comb begin
      o_hit   = 1'b0;
      o_ready = 1'b0;
      o_data  = '0;
      w_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_headIdx + IW'(k);
         if (i_valid[w_idx] && (i_rd[w_idx] == i_addr) && (i_addr != '0)) begin
            o_hit   = 1'b1;
            o_ready = i_dvalid[w_idx];
            o_data  = i_data[w_idx];
         end
      end
   end

endmodule

// File: rtl/reg_writeback_queue.sv
// Register file write side: in-order queue of retiring results, load data fill
// from the response port, one register write per cycle, and two bypass ports.
module reg_writeback_queue
   import reg_writeback_queue_pkg::*;
#(
   parameter int XLEN  = RWQ_XLEN,
   parameter int AW    = RWQ_AW,
   parameter int DEPTH = RWQ_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rd,
   input  logic            in_is_load,
   input  logic [XLEN-1:0] in_data,
   input  logic            ld_resp_valid,
   input  logic [XLEN-1:0] ld_resp_data,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [AW-1:0]   q_rs1_addr,
   output logic            q_rs1_hit,
   output logic            q_rs1_ready,
   output logic [XLEN-1:0] q_rs1_data,
   input  logic [AW-1:0]   q_rs2_addr,
   output logic            q_rs2_hit,
   output logic            q_rs2_ready,
   output logic [XLEN-1:0] q_rs2_data,
   output logic            empty
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = rwqPtrWidth(DEPTH);

   logic [PW-1:0]              r_head;
   logic [PW-1:0]              r_tail;
   logic [DEPTH-1:0][AW-1:0]   r_rd;
   logic [DEPTH-1:0][XLEN-1:0] r_data;
   logic [DEPTH-1:0]           r_dvalid;

   logic [IW-1:0]    w_headIdx;
   logic [IW-1:0]    w_tailIdx;
   logic [PW-1:0]    w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_enq;
   logic             w_drain;
   logic [DEPTH-1:0] w_valid;
   logic             w_fillHit;
   logic [IW-1:0]    w_fillIdx;
   logic [IW-1:0]    w_scanIdx;
   logic             w_fill;

   assign w_headIdx = r_head[IW-1:0];
   assign w_tailIdx = r_tail[IW-1:0];
   assign w_count   = r_tail - r_head;
   assign w_empty   = (r_head == r_tail);
   assign w_full    = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);

   // Slot g is occupied when its distance from the head is below the fill count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_valid
      logic [IW-1:0] w_off;
      assign w_off      = IW'(g) - w_headIdx;
      assign w_valid[g] = ({1'b0, w_off} < w_count);
   end

   assign w_enq   = in_valid && !w_full;
   assign w_drain = !w_empty && r_dvalid[w_headIdx];

   // Oldest unfilled load; w_valid comes from registers, so a load enqueued
   // this cycle cannot be claimed by a response arriving in the same cycle.
   always_comb begin
      w_fillHit = 1'b0;
      w_fillIdx = '0;
      w_scanIdx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_scanIdx = w_headIdx + IW'(k);
         if (!w_fillHit && w_valid[w_scanIdx] && !r_dvalid[w_scanIdx]) begin
            w_fillHit = 1'b1;
            w_fillIdx = w_scanIdx;
         end
      end
   end

   assign w_fill = ld_resp_valid && w_fillHit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_dvalid <= '0;
      end else begin
         if (w_enq) begin
            r_tail              <= r_tail + PW'(1);
            r_dvalid[w_tailIdx] <= !in_is_load;
         end
         if (w_fill) begin
            r_dvalid[w_fillIdx] <= 1'b1;
         end
         if (w_drain) begin
            r_head <= r_head + PW'(1);
         end
      end
   end

   // Payload storage is only meaningful under the valid/dvalid bits, so it is not reset.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_rd[w_tailIdx]   <= in_rd;
         r_data[w_tailIdx] <= in_is_load ? '0 : in_data;
      end
      if (w_fill) begin
         r_data[w_fillIdx] <= ld_resp_data;
      end
   end

   assign in_ready = !w_full;
   assign empty    = w_empty;
   assign rf_waddr = r_rd[w_headIdx];
   assign rf_wdata = r_data[w_headIdx];
   assign rf_we    = w_drain && (r_rd[w_headIdx] != '0);

   rwq_match #(
      .XLEN (XLEN),
      .AW   (AW),
      .DEPTH(DEPTH),
      .IW   (IW)
   ) u_matchRs1 (
      .i_headIdx(w_headIdx),
      .i_valid  (w_valid),
      .i_dvalid (r_dvalid),
      .i_rd     (r_rd),
      .i_data   (r_data),
      .i_addr   (q_rs1_addr),
      .o_hit    (q_rs1_hit),
      .o_ready  (q_rs1_ready),
      .o_data   (q_rs1_data)
   );

   rwq_match #(
      .XLEN (XLEN),
      .AW   (AW),
      .DEPTH(DEPTH),
      .IW   (IW)
   ) u_matchRs2 (
      .i_headIdx(w_headIdx),
      .i_valid  (w_valid),
      .i_dvalid (r_dvalid),
      .i_rd     (r_rd),
      .i_data   (r_data),
      .i_addr   (q_rs2_addr),
      .o_hit    (q_rs2_hit),
      .o_ready  (q_rs2_ready),
      .o_data   (q_rs2_data)
   );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: drain latency, load stalls and fills,
// full handling with wrap, bypass priority, dropped responses and reset.
module tb_reg_writeback_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_is_load;
   logic [31:0] in_data;
   logic        ld_resp_valid;
   logic [31:0] ld_resp_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  q_rs1_addr;
   logic        q_rs1_hit;
   logic        q_rs1_ready;
   logic [31:0] q_rs1_data;
   logic [4:0]  q_rs2_addr;
   logic        q_rs2_hit;
   logic        q_rs2_ready;
   logic [31:0] q_rs2_data;
   logic        empty;

   int checks = 0;
   int errors = 0;

   reg_writeback_queue dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rd        (in_rd),
      .in_is_load   (in_is_load),
      .in_data      (in_data),
      .ld_resp_valid(ld_resp_valid),
      .ld_resp_data (ld_resp_data),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .q_rs1_addr   (q_rs1_addr),
      .q_rs1_hit    (q_rs1_hit),
      .q_rs1_ready  (q_rs1_ready),
      .q_rs1_data   (q_rs1_data),
      .q_rs2_addr   (q_rs2_addr),
      .q_rs2_hit    (q_rs2_hit),
      .q_rs2_ready  (q_rs2_ready),
      .q_rs2_data   (q_rs2_data),
      .empty        (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic isLoad,
                                input logic [31:0] data, input logic rv, input logic [31:0] rdata);
      in_valid      = v;
      in_rd         = rd;
      in_is_load    = isLoad;
      in_data       = data;
      ld_resp_valid = rv;
      ld_resp_data  = rdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkWrite(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data);
      checkOutput({tag, ".we"}, 32'(rf_we), 32'(we));
      if (we) begin
         checkOutput({tag, ".waddr"}, 32'(rf_waddr), 32'(addr));
         checkOutput({tag, ".wdata"}, rf_wdata, data);
      end
   endtask

   task automatic query1(input string tag, input logic [4:0] addr, input logic hit, input logic rdy, input logic [31:0] data);
      q_rs1_addr = addr;
      #1;
      checkOutput({tag, ".hit1"}, 32'(q_rs1_hit), 32'(hit));
      checkOutput({tag, ".ready1"}, 32'(q_rs1_ready), 32'(rdy));
      checkOutput({tag, ".data1"}, q_rs1_data, data);
   endtask

   task automatic query2(input string tag, input logic [4:0] addr, input logic hit, input logic rdy, input logic [31:0] data);
      q_rs2_addr = addr;
      #1;
      checkOutput({tag, ".hit2"}, 32'(q_rs2_hit), 32'(hit));
      checkOutput({tag, ".ready2"}, 32'(q_rs2_ready), 32'(rdy));
      checkOutput({tag, ".data2"}, q_rs2_data, data);
   endtask

   initial begin
      reset      = 1'b1;
      q_rs1_addr = '0;
      q_rs2_addr = '0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst.empty", 32'(empty), 32'd1);
      checkOutput("rst.ready", 32'(in_ready), 32'd1);
      checkOutput("rst.we", 32'(rf_we), 32'd0);
      query1("rst", 5'd5, 0, 0, 32'h0);

      $display("[TB] single ALU entry");
      applyStimulus(1, 5'd5, 0, 32'hDEADBEEF, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkWrite("alu", 1, 5'd5, 32'hDEADBEEF);
      checkOutput("alu.empty", 32'(empty), 32'd0);
      query1("alu.drainhit", 5'd5, 1, 1, 32'hDEADBEEF);
      step();
      checkOutput("alu.emptyAfter", 32'(empty), 32'd1);
      checkOutput("alu.weAfter", 32'(rf_we), 32'd0);

      $display("[TB] load at head then ALU");
      applyStimulus(1, 5'd7, 1, 32'h12345678, 0, 0);
      step();
      applyStimulus(1, 5'd8, 0, 32'h11, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("ldwait.we", 32'(rf_we), 32'd0);
         query1("ldwait", 5'd7, 1, 0, 32'h0);
         step();
      end
      applyStimulus(0, 0, 0, 0, 1, 32'hCAFE);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkWrite("ld.rd7", 1, 5'd7, 32'hCAFE);
      step();
      checkWrite("ld.rd8", 1, 5'd8, 32'h11);
      step();
      checkOutput("ld.empty", 32'(empty), 32'd1);

      $display("[TB] fill to full with stalled head");
      applyStimulus(1, 5'd9, 1, 32'h0, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 5'(10 + i), 0, 32'hA0 + 32'(i), 0, 0);
         step();
         if (i == 1) checkOutput("full.readyAt3", 32'(in_ready), 32'd1);
      end
      checkOutput("full.ready", 32'(in_ready), 32'd0);
      applyStimulus(1, 5'd13, 0, 32'hBAD, 0, 0);
      step();
      step();
      checkOutput("full.readyHeld", 32'(in_ready), 32'd0);
      checkOutput("full.we", 32'(rf_we), 32'd0);
      query1("full.noOverwrite", 5'd13, 0, 0, 32'h0);
      query1("full.tail", 5'd12, 1, 1, 32'hA2);
      applyStimulus(0, 0, 0, 0, 1, 32'h99);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkWrite("wrap.rd9", 1, 5'd9, 32'h99);
      checkOutput("wrap.readyWhileDrain", 32'(in_ready), 32'd0);
      step();
      checkWrite("wrap.rd10", 1, 5'd10, 32'hA0);
      checkOutput("wrap.readyAfter", 32'(in_ready), 32'd1);
      step();
      checkWrite("wrap.rd11", 1, 5'd11, 32'hA1);
      step();
      checkWrite("wrap.rd12", 1, 5'd12, 32'hA2);
      step();
      checkOutput("wrap.empty", 32'(empty), 32'd1);
      checkOutput("wrap.we", 32'(rf_we), 32'd0);

      $display("[TB] bypass priority and rd=0");
      applyStimulus(1, 5'd20, 1, 32'h0, 0, 0);
      step();
      applyStimulus(1, 5'd3, 0, 32'h1, 0, 0);
      step();
      applyStimulus(1, 5'd3, 0, 32'h2, 0, 0);
      step();
      applyStimulus(1, 5'd0, 0, 32'h55, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      query2("byp.youngest", 5'd3, 1, 1, 32'h2);
      query1("byp.zero", 5'd0, 0, 0, 32'h0);
      query1("byp.pendLoad", 5'd20, 1, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 32'h77);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkWrite("byp.rd20", 1, 5'd20, 32'h77);
      step();
      checkWrite("byp.rd3a", 1, 5'd3, 32'h1);
      query2("byp.duringDrain", 5'd3, 1, 1, 32'h2);
      step();
      checkWrite("byp.rd3b", 1, 5'd3, 32'h2);
      step();
      checkOutput("byp.rd0we", 32'(rf_we), 32'd0);
      checkOutput("byp.rd0notEmpty", 32'(empty), 32'd0);
      step();
      checkOutput("byp.empty", 32'(empty), 32'd1);

      $display("[TB] stray and same-cycle responses, two loads");
      applyStimulus(0, 0, 0, 0, 1, 32'h1234);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("stray.empty", 32'(empty), 32'd1);
      checkOutput("stray.we", 32'(rf_we), 32'd0);
      applyStimulus(1, 5'd16, 1, 32'h0, 1, 32'h5A);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("same.we", 32'(rf_we), 32'd0);
      query1("same.notFilled", 5'd16, 1, 0, 32'h0);
      step();
      checkOutput("same.weLater", 32'(rf_we), 32'd0);
      applyStimulus(1, 5'd14, 1, 32'h0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 1, 32'hAA);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkWrite("two.older", 1, 5'd16, 32'hAA);
      query1("two.youngerPending", 5'd14, 1, 0, 32'h0);
      step();
      checkOutput("two.stall", 32'(rf_we), 32'd0);
      checkOutput("two.notEmpty", 32'(empty), 32'd0);
      applyStimulus(0, 0, 0, 0, 1, 32'hBB);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkWrite("two.younger", 1, 5'd14, 32'hBB);
      step();
      checkOutput("two.empty", 32'(empty), 32'd1);

      $display("[TB] reset with pending loads");
      applyStimulus(1, 5'd17, 1, 32'h0, 0, 0);
      step();
      applyStimulus(1, 5'd18, 1, 32'h0, 0, 0);
      step();
      applyStimulus(1, 5'd19, 0, 32'h3, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("prer.empty", 32'(empty), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("mr.empty", 32'(empty), 32'd1);
      checkOutput("mr.we", 32'(rf_we), 32'd0);
      checkOutput("mr.ready", 32'(in_ready), 32'd1);
      query1("mr.alu", 5'd19, 0, 0, 32'h0);
      query2("mr.load", 5'd17, 0, 0, 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 32'hEE);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("late.empty", 32'(empty), 32'd1);
      checkOutput("late.we", 32'(rf_we), 32'd0);
      step();
      checkOutput("late.weNext", 32'(rf_we), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
